// File: rtl/fp_mac_pkg.sv
// rtl/fp_mac_pkg.sv - shared FP32 constants and accumulator FSM state type
// Purpose : common definitions for fp_accum_ctrl and its adder.
// Ports   : none (package).
package fp_mac_pkg;

  localparam int FP_W    = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Exponent field all ones marks Inf or NaN.
  function automatic logic exp_all_ones(input logic [FP_W-1:0] x);
    return &x[EXP_MSB:EXP_LSB];
  endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - combinational IEEE-754 single-precision adder
// Purpose : sum = a + b, round-to-nearest-even, subnormals supported.
// Ports   : a   [31:0] in  - operand A
//           b   [31:0] in  - operand B
//           sum [31:0] out - rounded sum
module adder
  import fp_mac_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum
);

  logic [FP_W-1:0] w_l;
  logic [FP_W-1:0] w_s;
  logic [7:0]      w_el;
  logic [7:0]      w_es;
  logic [7:0]      w_d;
  logic [23:0]     w_ml;
  logic [23:0]     w_ms;
  logic [26:0]     w_lx;
  logic [26:0]     w_sx;
  logic [26:0]     w_mask;
  logic [27:0]     w_raw;
  logic [26:0]     w_n;
  logic [9:0]      w_e;
  logic            w_rup;
  logic [24:0]     w_r;

  always_comb begin
    w_l    = a;
    w_s    = b;
    w_d    = 8'd0;
    w_sx   = 27'd0;
    w_mask = 27'd0;
    w_raw  = 28'd0;
    w_n    = 27'd0;
    w_e    = 10'd0;
    w_rup  = 1'b0;
    w_r    = 25'd0;
    sum    = FP_ZERO;

    // Order by magnitude so the subtraction below never goes negative.
    if (b[30:0] > a[30:0]) begin
      w_l = b;
      w_s = a;
    end
    // Subnormals carry an effective exponent of 1 and no hidden bit.
    w_el = (w_l[EXP_MSB:EXP_LSB] == 8'd0) ? 8'd1 : w_l[EXP_MSB:EXP_LSB];
    w_es = (w_s[EXP_MSB:EXP_LSB] == 8'd0) ? 8'd1 : w_s[EXP_MSB:EXP_LSB];
    w_ml = {|w_l[EXP_MSB:EXP_LSB], w_l[22:0]};
    w_ms = {|w_s[EXP_MSB:EXP_LSB], w_s[22:0]};
    w_d  = w_el - w_es;

    // Three extra low bits hold guard, round and sticky.
    w_lx = {w_ml, 3'b000};
    if (w_d > 8'd26) begin
      w_sx = {26'd0, |w_ms};
    end else begin
      w_mask = (27'd1 << w_d) - 27'd1;
      w_sx   = ({w_ms, 3'b000} >> w_d) | {26'd0, |({w_ms, 3'b000} & w_mask)};
    end

    if (w_l[31] == w_s[31]) w_raw = {1'b0, w_lx} + {1'b0, w_sx};
    else                    w_raw = {1'b0, w_lx} - {1'b0, w_sx};

    w_e = {2'b00, w_el};
    if (w_raw[27]) begin
      w_n = w_raw[27:1] | {26'd0, w_raw[0]};
      w_e = w_e + 10'd1;
    end else begin
      w_n = w_raw[26:0];
      // Left-normalise, stopping at exponent 1 so results fall into subnormal range.
      for (int i = 0; i < 26; i++) begin
        if (!w_n[26] && (w_e > 10'd1)) begin
          w_n = w_n << 1;
          w_e = w_e - 10'd1;
        end
      end
    end

    w_rup = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_r   = {1'b0, w_n[26:3]} + {24'd0, w_rup};
    if (w_r[24]) begin
      w_r = w_r >> 1;
      w_e = w_e + 10'd1;
    end

    if (w_e >= 10'd255) sum = {w_l[31], 8'hFF, 23'd0};
    else                sum = {w_l[31], (w_r[23] ? w_e[7:0] : 8'd0), w_r[22:0]};

    if (w_raw == 28'd0) sum = FP_ZERO;

    // Special operands bypass the arithmetic path.
    if (exp_all_ones(a) || exp_all_ones(b)) begin
      if ((exp_all_ones(a) && (a[22:0] != 23'd0)) ||
          (exp_all_ones(b) && (b[22:0] != 23'd0)))
        sum = FP_QNAN;
      else if (exp_all_ones(a) && exp_all_ones(b) && (a[31] != b[31]))
        sum = FP_QNAN;
      else if (exp_all_ones(a))
        sum = a;
      else
        sum = b;
    end
  end

endmodule

// File: rtl/fp_accum_ctrl.sv
// rtl/fp_accum_ctrl.sv - FP32 accumulation job controller
// Purpose : accepts a job of len FP32 operands and returns their running sum.
//           Optional macro FP_ACCUM_SPECIAL_FLAG_EN adds a sticky Inf/NaN flag.
// Ports   : clk, rst (async, active-high)
//           start, len[LEN_W-1:0]            - job request, sampled in IDLE
//           in_valid, in_data[31:0], in_ready - operand stream
//           out_valid, out_sum[31:0], out_ready - result handshake
//           busy                              - not IDLE
//           special_flag (macro only)         - acc has held Inf/NaN this job
module fp_accum_ctrl
  import fp_mac_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [FP_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [FP_W-1:0]  out_sum,
  input  logic             out_ready,
`ifdef FP_ACCUM_SPECIAL_FLAG_EN
  output logic             special_flag,
`endif
  output logic             busy
);

  state_t           r_state;
  state_t           w_next;
  logic [FP_W-1:0]  r_acc;
  logic [LEN_W-1:0] r_rem;
  logic             r_have_acc;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;
  logic             w_xfer;
  logic             w_start_ok;
  logic [FP_W-1:0]  w_sum;
  logic [FP_W-1:0]  w_acc_d;

  adder u_adder (
    .a   (r_acc),
    .b   (in_data),
    .sum (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = (len == '0) ? ST_DONE : ST_ACC;
      end
      ST_ACC: begin
        w_in_ready = 1'b1;
        if (in_valid && (r_rem == LEN_W'(1))) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_xfer     = w_in_ready & in_valid;
  assign w_start_ok = (r_state == ST_IDLE) & start;
  // First operand of a job is loaded as-is; later ones go through the adder.
  assign w_acc_d    = r_have_acc ? w_sum : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= FP_ZERO;
      r_rem      <= '0;
      r_have_acc <= 1'b0;
    end else if (w_start_ok) begin
      r_rem      <= len;
      r_have_acc <= 1'b0;
      if (len == '0) r_acc <= FP_ZERO;
    end else if (w_xfer) begin
      r_acc      <= w_acc_d;
      r_rem      <= r_rem - LEN_W'(1);
      r_have_acc <= 1'b1;
    end
  end

`ifdef FP_ACCUM_SPECIAL_FLAG_EN
  logic r_special;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_special <= 1'b0;
    else if (w_start_ok)                      r_special <= 1'b0;
    else if (w_xfer && exp_all_ones(w_acc_d)) r_special <= 1'b1;
  end

  assign special_flag = r_special;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_sum   = r_acc;
  assign busy      = w_busy;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// tb/tb_fp_accum_ctrl.sv - scoreboard bench for fp_accum_ctrl
module tb_fp_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_sum;
  logic        out_ready;
  logic        busy;
`ifdef FP_ACCUM_SPECIAL_FLAG_EN
  logic        special_flag;
`endif

  int n_checks = 0;
  int n_errs   = 0;
  logic [31:0] exp_q[$];

  fp_accum_ctrl #(.LEN_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_ready (out_ready),
`ifdef FP_ACCUM_SPECIAL_FLAG_EN
    .special_flag (special_flag),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Result monitor: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_result: got %h expected none", out_sum);
      end else begin
        chk("result", out_sum, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] ops_b[3];
  logic [31:0] part_b[3];

  initial begin
    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in_data = 32'd0; out_ready = 1'b0;
    cyc; cyc;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    cyc;

    // 1.0 + 1.0 back-to-back
    start = 1'b1; len = 8'd2; exp_q.push_back(32'h4000_0000);
    cyc;
    chk("a_busy", {31'd0, busy}, 32'd1);
    chk("a_in_ready", {31'd0, in_ready}, 32'd1);
    start = 1'b0; in_valid = 1'b1; in_data = 32'h3F80_0000;
    cyc;
    chk("a_ov_early", {31'd0, out_valid}, 32'd0);
    cyc;
    chk("a_ov_latency", {31'd0, out_valid}, 32'd1);
    chk("a_in_ready_done", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc;
    out_ready = 1'b0;
    chk("a_idle_ov", {31'd0, out_valid}, 32'd0);
    chk("a_idle_busy", {31'd0, busy}, 32'd0);

    // 2.0 + 1.0 + 1.0 with two idle cycles between operands
    ops_b[0] = 32'h4000_0000; ops_b[1] = 32'h3F80_0000; ops_b[2] = 32'h3F80_0000;
    part_b[0] = 32'h4000_0000; part_b[1] = 32'h4040_0000; part_b[2] = 32'h4080_0000;
    start = 1'b1; len = 8'd3; exp_q.push_back(32'h4080_0000);
    cyc;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = ops_b[i];
      cyc;
      in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
      chk("b_acc", out_sum, part_b[i]);
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          cyc;
          chk("b_gap_acc", out_sum, part_b[i]);
          chk("b_gap_ov", {31'd0, out_valid}, 32'd0);
        end
      end
    end
    chk("b_ov", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    cyc;
    out_ready = 1'b0;

    // zero-length job
    start = 1'b1; len = 8'd0; exp_q.push_back(32'h0000_0000);
    cyc;
    start = 1'b0;
    chk("c_ov", {31'd0, out_valid}, 32'd1);
    chk("c_sum", out_sum, 32'h0000_0000);
    chk("c_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    cyc;
    out_ready = 1'b0;

    // backpressure in DONE with start pulsing
    start = 1'b1; len = 8'd1; exp_q.push_back(32'h4040_0000);
    cyc;
    start = 1'b0; in_valid = 1'b1; in_data = 32'h4040_0000;
    cyc;
    in_valid = 1'b0;
    start = 1'b1; len = 8'd2;
    for (int k = 0; k < 5; k++) begin
      cyc;
      chk("d_ov_hold", {31'd0, out_valid}, 32'd1);
      chk("d_sum_hold", out_sum, 32'h4040_0000);
      chk("d_in_ready", {31'd0, in_ready}, 32'd0);
    end
    start = 1'b0; out_ready = 1'b1;
    cyc;
    out_ready = 1'b0;
    chk("d_idle_ov", {31'd0, out_valid}, 32'd0);
    chk("d_idle_busy", {31'd0, busy}, 32'd0);

    // reset mid-job, then a one-operand job
    start = 1'b1; len = 8'd3;
    cyc;
    start = 1'b0; in_valid = 1'b1; in_data = 32'h4000_0000;
    cyc;
    in_valid = 1'b0;
    chk("e_partial", out_sum, 32'h4000_0000);
    rst = 1'b1;
    #1;
    chk("e_rst_sum", out_sum, 32'd0);
    chk("e_rst_busy", {31'd0, busy}, 32'd0);
    chk("e_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("e_rst_ov", {31'd0, out_valid}, 32'd0);
    cyc;
    rst = 1'b0;
    start = 1'b1; len = 8'd1; exp_q.push_back(32'h3F80_0000);
    cyc;
    start = 1'b0; in_valid = 1'b1; in_data = 32'h3F80_0000;
    cyc;
    in_valid = 1'b0;
    chk("e_ov", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    cyc;
    out_ready = 1'b0;

`ifdef FP_ACCUM_SPECIAL_FLAG_EN
    start = 1'b1; len = 8'd2; exp_q.push_back(32'h7F80_0000);
    cyc;
    start = 1'b0; in_valid = 1'b1; in_data = 32'h7F80_0000;
    cyc;
    in_data = 32'h3F80_0000;
    cyc;
    in_valid = 1'b0;
    chk("f_flag_done", {31'd0, special_flag}, 32'd1);
    cyc;
    chk("f_flag_hold", {31'd0, special_flag}, 32'd1);
    out_ready = 1'b1;
    cyc;
    out_ready = 1'b0;
    start = 1'b1; len = 8'd0; exp_q.push_back(32'h0000_0000);
    cyc;
    start = 1'b0;
    chk("f_flag_clr", {31'd0, special_flag}, 32'd0);
    out_ready = 1'b1;
    cyc;
    out_ready = 1'b0;
`endif

    for (int w = 0; w < 10 && exp_q.size() != 0; w++) cyc;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_accum_ctrl.md
FP_ACCUM_CTRL -- requirements
Module: fp_accum_ctrl

Interface
REQ-001 SHALL have parameter: LEN_W, 8, width of operand-count input and internal remaining counter.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  begin accumulation job; sampled only in IDLE.
REQ-005 SHALL have port: len  input  LEN_W  number of FP32 operands in the job, sampled with start.
REQ-006 SHALL have port: in_valid  input  1  operand present on in_data.
REQ-007 SHALL have port: in_data  input  32  IEEE-754 single-precision operand.
REQ-008 SHALL have port: in_ready  output  1  controller accepts operand this cycle.
REQ-009 SHALL have port: out_valid  output  1  out_sum holds final job result.
REQ-010 SHALL have port: out_sum  output  32  accumulated FP32 sum.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ACC, DONE.
REQ-014 IDLE: start=1, len!=0 -> load remaining counter with len, clear first-operand flag, go ACC.
REQ-015 IDLE: start=1, len=0 -> acc <= 32'h00000000, go DONE.
REQ-016 start SHALL be ignored in ACC and DONE.
REQ-017 in_ready SHALL be 1 only in ACC; transfer occurs when in_valid & in_ready.
REQ-018 First transfer of a job SHALL copy in_data into acc unmodified (no addition).
REQ-019 Each later transfer SHALL register acc <= adder sum of (a=acc, b=in_data), computed combinationally in the same cycle.
REQ-020 Each transfer SHALL decrement remaining; transfer with remaining=1 SHALL move to DONE.
REQ-021 Cycles in ACC without in_valid SHALL hold acc and remaining unchanged.
REQ-022 DONE: out_valid=1, out_sum=acc; out_valid & out_ready -> IDLE next cycle.
REQ-023 out_valid SHALL rise the cycle after the final transfer; out_sum SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 One operand per cycle sustained throughput; job of N operands with no stalls completes in N+1 cycles from start to out_valid.
REQ-025 out_sum SHALL be driven from acc register only (no combinational path from in_data).

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, acc=0, remaining=0, in_ready=0, out_valid=0, out_sum=0, busy=0.
REQ-027 Reset mid-job SHALL discard the job; no partial result is ever presented.

Configuration
REQ-028 Macro FP_ACCUM_SPECIAL_FLAG_EN defined: output port special_flag (1 bit) SHALL go 1 the cycle after acc is written with exponent field 8'hFF (Inf/NaN), remain sticky through DONE, clear on accepted start and on reset.
REQ-029 Macro undefined: special_flag port and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-030 Shared package fp_mac_pkg SHALL hold FP_W=32, FP_ZERO, exponent field msb/lsb constants (30/23), and the FSM state enum type.
REQ-031 SHALL instantiate existing combinational sub-module adder (ports a, b, sum) exactly once; no other sub-modules.

Verification
REQ-032 start len=2; feed 32'h3F800000, 32'h3F800000 back-to-back -> out_valid on cycle 3, out_sum=32'h40000000.
REQ-033 start len=3; feed 32'h40000000, 32'h3F800000, 32'h3F800000 with 2 idle in_valid=0 cycles between each -> out_sum=32'h40800000, acc unchanged during gaps.
REQ-034 start len=0 -> out_valid next cycle, out_sum=32'h00000000, in_ready never 1.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while pulsing start -> out_valid and out_sum stable, in_ready=0, start ignored; out_ready=1 -> IDLE next cycle.
REQ-036 Assert rst after 1 of 3 operands -> all outputs 0 immediately; then len=1 with 32'h3F800000 -> out_sum=32'h3F800000.
REQ-037 With FP_ACCUM_SPECIAL_FLAG_EN: len=2, feed 32'h7F800000, 32'h3F800000 -> special_flag=1 through DONE, 0 after next accepted start.
